// File: rtl/gpio_irq_if.sv
// ---------------------------------------------------------------------------
// gpio_irq_if
//   Word-addressed register bus between the core's data-memory port and the
//   GPIO peripheral. There are no wait states. A write completes on the
//   clock edge where we=1. rdata is combinational from addr.
//
//   addr   [2:0]       register select
//   we                 write strobe, one write per asserted cycle
//   wdata  [WIDTH-1:0] write data
//   rdata  [WIDTH-1:0] read data (peripheral -> core)
// ---------------------------------------------------------------------------
interface gpio_irq_if #(
   parameter int WIDTH = 32
) ();
   logic [2:0]       addr;
   logic             we;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;

   modport master (output addr, output we, output wdata, input rdata);
   modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/gpio_irq.sv
// ---------------------------------------------------------------------------
// gpio_irq
//   Parametrised GPIO port. It provides per-pin direction, tri-state output
//   drive and a synchronised input. Output bits can be set or cleared
//   atomically. Rising and/or falling edges on each pin can raise an
//   interrupt, with a write-1-to-clear status register.
//
//   i_clk    system clock, all state on rising edge
//   i_rst_n  asynchronous reset, active low
//   bus      register bus (slave side): addr, we, wdata, rdata
//   io_gpio  pads; pin i is driven only when DDIR[i]=1
//   o_irq    level interrupt, OR of all IRQ_STAT bits
//
//   Register map (bus.addr):
//     0 DOUT RW | 1 DDIR RW (1=output) | 2 DIN RO | 3 DOUT_SET W1S
//     4 DOUT_CLR W1C | 5 RISE_EN RW | 6 FALL_EN RW | 7 IRQ_STAT RO/W1C
// ---------------------------------------------------------------------------
module gpio_irq #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   gpio_irq_if.slave        bus,
   inout  wire  [WIDTH-1:0] io_gpio,
   output logic             o_irq
);

   typedef enum logic [2:0] {
      REG_DOUT     = 3'd0,
      REG_DDIR     = 3'd1,
      REG_DIN      = 3'd2,
      REG_DOUT_SET = 3'd3,
      REG_DOUT_CLR = 3'd4,
      REG_RISE_EN  = 3'd5,
      REG_FALL_EN  = 3'd6,
      REG_IRQ_STAT = 3'd7
   } reg_e;

   localparam int               CW        = $clog2(SYNC_STAGES + 1);
   localparam logic [CW-1:0]    WARM_DONE = CW'(SYNC_STAGES);

   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] ddir_q, ddir_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] irq_stat_q, irq_stat_d;
   logic [CW-1:0]    warm_q, warm_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

   logic [WIDTH-1:0] din, din_next, irq_set, irq_clr;
   reg_e             sel;

   assign sel      = reg_e'(bus.addr);
   assign din      = sync_q[SYNC_STAGES-1];
   assign din_next = sync_q[SYNC_STAGES-2];

   // Pad drivers. An output pin also feeds its own synchroniser, so DIN reads
   // back the driven level.
   for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      assign io_gpio[i] = ddir_q[i] ? dout_q[i] : 1'bz;
   end

   always_comb begin
      // NOTE: every signal gets a default here, so no path leaves one
      // unassigned and no latch can be inferred.
      dout_d    = dout_q;
      ddir_d    = ddir_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      warm_d    = warm_q;
      irq_set   = '0;
      irq_clr   = '0;

      sync_d[0] = io_gpio;
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];

      // After reset the chain still holds zeros rather than pad samples.
      // Edge detection stays off until every stage has been loaded. Without
      // this, a pin tied high would look like a rising edge.
      if (warm_q != WARM_DONE) begin
         warm_d = warm_q + 1'b1;
      end else begin
         irq_set = (din_next & ~din & rise_en_q) | (~din_next & din & fall_en_q);
      end

      if (bus.we) begin
         unique case (sel)
            REG_DOUT:     dout_d    = bus.wdata;
            REG_DDIR:     ddir_d    = bus.wdata;
            REG_DOUT_SET: dout_d    = dout_q | bus.wdata;
            REG_DOUT_CLR: dout_d    = dout_q & ~bus.wdata;
            REG_RISE_EN:  rise_en_d = bus.wdata;
            REG_FALL_EN:  fall_en_d = bus.wdata;
            REG_IRQ_STAT: irq_clr   = bus.wdata;
            default:      ;  // DIN is read-only
         endcase
      end

      // A new event in the same cycle as its W1C wins, so it is not lost.
      irq_stat_d = (irq_stat_q & ~irq_clr) | irq_set;
   end

   always_comb begin
      unique case (sel)
         REG_DDIR:     bus.rdata = ddir_q;
         REG_DIN:      bus.rdata = din;
         REG_RISE_EN:  bus.rdata = rise_en_q;
         REG_FALL_EN:  bus.rdata = fall_en_q;
         REG_IRQ_STAT: bus.rdata = irq_stat_q;
         default:      bus.rdata = dout_q;  // DOUT, DOUT_SET, DOUT_CLR
      endcase
   end

   assign o_irq = |irq_stat_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dout_q     <= '0;
         ddir_q     <= '0;
         rise_en_q  <= '0;
         fall_en_q  <= '0;
         irq_stat_q <= '0;
         warm_q     <= '0;
         sync_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every flop samples pre-edge
         // values. This is what makes the synchroniser a real shift chain.
         dout_q     <= dout_d;
         ddir_q     <= ddir_d;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         irq_stat_q <= irq_stat_d;
         warm_q     <= warm_d;
         sync_q     <= sync_d;
      end
   end

endmodule
